// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window producer: FSM state encoding and window container.
package sobel_pkg;

   localparam int SOBEL_DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_ACTIVE,
      S_FRAME_END
   } win_state_e;

   // Row-major 3x3 neighbourhood: element 0 is top-left, element 8 bottom-right.
   typedef logic [8:0][SOBEL_DATA_W-1:0] window_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel store indexed by column; a read returns the old word while the same
// address is being overwritten on this clock edge.
module sobel_line_buf #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window generator feeding sobel_calc.
// Optional start-of-frame resync input is enabled by defining SOBEL_WIN_SOF_EN.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int DATA_W     = SOBEL_DATA_W,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pixel_i,
   input  logic              valid_i,
   output logic [DATA_W-1:0] d0_o,
   output logic [DATA_W-1:0] d1_o,
   output logic [DATA_W-1:0] d2_o,
   output logic [DATA_W-1:0] d3_o,
   output logic [DATA_W-1:0] d4_o,
   output logic [DATA_W-1:0] d5_o,
   output logic [DATA_W-1:0] d6_o,
   output logic [DATA_W-1:0] d7_o,
   output logic [DATA_W-1:0] d8_o,
   output logic              done_o,
   output logic              frame_done_o,
   output win_state_e        state_o
`ifdef SOBEL_WIN_SOF_EN
   ,
   input  logic              sof_i
`endif
);

   // Handshake: a pixel is consumed on every rising edge where valid_i=1 (no back-pressure);
   // done_o=1 for exactly one cycle marks d0_o..d8_o as a fresh window.

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   win_state_e               state_q;
   logic [CW-1:0]            col_q, col_d, eff_col;
   logic [RW-1:0]            row_q, row_d, eff_row;
   logic [8:0][DATA_W-1:0]   sh_q, sh_d, win_q;
   logic                     done_q, frame_done_q;
   logic                     accept, sof_w, emit, last_col, last_pix, fill_end;
   logic [DATA_W-1:0]        lb0_rd, lb1_rd;

`ifdef SOBEL_WIN_SOF_EN
   assign sof_w = sof_i & valid_i;
`else
   assign sof_w = 1'b0;
`endif

   assign accept = valid_i;

   always_comb begin
      eff_col  = sof_w ? '0 : col_q;
      eff_row  = sof_w ? '0 : row_q;
      last_col = (eff_col == COL_LAST);
      last_pix = accept && last_col && (eff_row == ROW_LAST);
      fill_end = accept && last_col && (eff_row == RW'(1));
      emit     = accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      col_d    = col_q;
      row_d    = row_q;
      if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
         end else begin
            col_d = eff_col + CW'(1);
            row_d = eff_row;
         end
      end
      // Shift every row left; the new right column is {line r-2, line r-1, current pixel}.
      sh_d = sh_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            sh_d[3*r]   = sh_q[3*r+1];
            sh_d[3*r+1] = sh_q[3*r+2];
         end
         sh_d[2] = lb0_rd;
         sh_d[5] = lb1_rd;
         sh_d[8] = pixel_i;
      end
   end

   sobel_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (eff_col),
      .wdata_i(lb1_rd),
      .rdata_o(lb0_rd)
   );

   sobel_line_buf #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (eff_col),
      .wdata_i(pixel_i),
      .rdata_o(lb1_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         sh_q         <= '0;
         win_q        <= '0;
         done_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         sh_q         <= sh_d;
         done_q       <= emit;
         frame_done_q <= last_pix;
         if (emit) win_q <= sh_d;
         if (accept) begin
            if (sof_w)                                          state_q <= S_FILL;
            else if (last_pix)                                  state_q <= S_FRAME_END;
            else if (fill_end)                                  state_q <= S_ACTIVE;
            else if (state_q == S_IDLE || state_q == S_FRAME_END) state_q <= S_FILL;
         end else if (state_q == S_FRAME_END) begin
            state_q <= S_IDLE;
         end
      end
   end

   assign d0_o         = win_q[0];
   assign d1_o         = win_q[1];
   assign d2_o         = win_q[2];
   assign d3_o         = win_q[3];
   assign d4_o         = win_q[4];
   assign d5_o         = win_q[5];
   assign d6_o         = win_q[6];
   assign d7_o         = win_q[7];
   assign d8_o         = win_q[8];
   assign done_o       = done_q;
   assign frame_done_o = frame_done_q;
   assign state_o      = state_q;

endmodule
